// File: rtl/mac.sv
// mac: three-stage pipelined unsigned multiply-accumulate (register operands, register product, accumulate)
module mac #(
  parameter int IN_W     = 12,
  parameter int ACC_W    = 25,
  parameter bit SATURATE = 1'b0
) (
  input  logic [IN_W-1:0]  Ain,
  input  logic [IN_W-1:0]  Bin,
  input  logic             clk,
  input  logic             reset,
  output logic [ACC_W-1:0] Mac_out
);
  logic [IN_W-1:0]   a_q, b_q;
  logic [2*IN_W-1:0] prod_q;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    sum;
  // one extra bit keeps the carry so saturation can detect overflow
  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    acc_d = (SATURATE && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      a_q    <= Ain;
      b_q    <= Bin;
      prod_q <= a_q * b_q;
      acc_q  <= acc_d;
    end
  assign Mac_out = acc_q;
endmodule

// File: tb/tb_mac.sv
// tb_mac: scoreboard bench driving a wrapping and a saturating mac with the same operands
module tb_mac;
  localparam longint MAXV = (64'd1 << 25) - 1;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] Ain, Bin;
  logic [24:0] out_w, out_s;
  int vectors = 0;
  int miscompares = 0;
  longint mw, ms;
  longint qw[$], qs[$];

  mac #(.IN_W(12), .ACC_W(25), .SATURATE(1'b0)) dut_w (
    .Ain(Ain), .Bin(Bin), .clk(clk), .reset(reset), .Mac_out(out_w));
  mac #(.IN_W(12), .ACC_W(25), .SATURATE(1'b1)) dut_s (
    .Ain(Ain), .Bin(Bin), .clk(clk), .reset(reset), .Mac_out(out_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // expected value for an edge is the model sum from two edges earlier
  task automatic step(input int a, input int b);
    longint p;
    Ain = 12'(a);
    Bin = 12'(b);
    p  = longint'(a) * longint'(b);
    mw = (mw + p) % (MAXV + 1);
    ms = (ms + p > MAXV) ? MAXV : ms + p;
    qw.push_back(mw);
    qs.push_back(ms);
    @(posedge clk);
    #1;
    check("acc_wrap", out_w, 25'(qw.pop_front()));
    check("acc_sat", out_s, 25'(qs.pop_front()));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_now_w", out_w, 25'd0);
    check("reset_now_s", out_s, 25'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold_w", out_w, 25'd0);
      check("reset_hold_s", out_s, 25'd0);
    end
    mw = 0;
    ms = 0;
    qw = {0, 0};
    qs = {0, 0};
    reset = 1'b1;
  endtask

  initial begin
    Ain = '0;
    Bin = '0;
    reset = 1'b0;
    #2;
    do_reset();
    repeat (6) step(3, 5);
    do_reset();
    repeat (5) step(4095, 4095);
    check("wrap_value", out_w, 25'd16752643);
    check("sat_value", out_s, 25'd33554431);
    step(4095, 4095);
    check("sat_hold", out_s, 25'd33554431);
    do_reset();
    repeat (4) step(3, 5);
    #2;
    do_reset();
    repeat (4) step(2, 2);
    repeat (3) step(7, 9);
    for (int i = 0; i <= 100; i++) step(i, 0);
    check("zero_sweep_w", out_w, 25'(16 + 3 * 63));
    do_reset();
    for (int i = 0; i < 30; i++) step(i / 3, 1);
    repeat (2) step(0, 0);
    check("ramp_total", out_w, 25'd135);
    for (int i = 0; i < 20; i++) step($urandom_range(0, 4095), $urandom_range(0, 4095));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
